rng_share_ctrl: RTL and testbench
=================================

Name: rng_share_ctrl

Overview:
- Owns one 9-bit XNOR LFSR random source and shares it between N_REQ requesters (game logic, placement, timers) using round-robin arbitration.
- For each granted request, discards STRIDE steps of the LFSR to decorrelate consecutive draws.
- Rejects samples above LIMIT, then returns one value with a one-cycle ack pulse.
- Sits between the free-running random source and all consumers needing random numbers.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- STRIDE, 4, LFSR steps between grant and first sample (>=1).
- LIMIT, 9'd511, largest value accepted; samples > LIMIT are rejected.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  level request per requester.
- ack  out  N_REQ  one-hot, one-cycle pulse; rand_out is valid while it is high.
- rand_out  out  9  delivered random value.
- grant_id  out  clog2(N_REQ)  index of the current or last winner.
- busy  out  1  high when the FSM is not in IDLE.
- seed_load  in  1  load seed into the LFSR this edge.
- seed  in  9  seed value.
- lfsr_state  out  9  current LFSR register, for observability.

Behaviour:
- Reset (synchronous, active-high), applies even mid-transaction: lfsr=0x000, state=IDLE, ack=0, rand_out=0x000, grant_id=0, RR pointer=0, busy=0. Any pending grant is abandoned with no ack.
- LFSR:
  - Steps every cycle when not in reset: next = {s[0] XNOR s[4], s[8:1]}.
  - From 0x000 the sequence is 100,180,1C0,1E0,1F0,0F8,07C,03E,01F,10F.
  - seed_load has priority over stepping. Loading 0x1FF (the lockup state) stores 0x000 instead.
  - seed_load is allowed in any FSM state and does not disturb the FSM or its counter.
- Arbitration, evaluated in IDLE only:
  - Winner = first set bit of req scanning pointer, pointer+1, ... mod N_REQ.
  - At that edge: grant_id<=winner, cnt<=STRIDE-1, state<=WAIT.
  - No req set: stay IDLE.
- WAIT:
  - cnt!=0: cnt<=cnt-1.
  - cnt==0 and lfsr_state<=LIMIT: rand_out<=lfsr_state, ack<=onehot(grant_id), pointer<=(grant_id+1) mod N_REQ, state<=HOLD.
  - cnt==0 and lfsr_state>LIMIT: remain in WAIT and retest next cycle. This is bounded, since every value except 0x1FF appears within 511 steps.
- HOLD: lasts exactly one cycle with ack high; then ack<=0, state<=IDLE. rand_out holds its value until the next accept.
- Handshake:
  - req is level-sensitive; ack is the completion.
  - A req still high in the IDLE cycle after HOLD is treated as a new request.
  - A req dropped during WAIT does not cancel the grant; ack still pulses.
- Latency:
  - Request sampled in IDLE in cycle k: with no rejections, ack is high in cycle k+STRIDE+1.
  - Back-to-back grants repeat every STRIDE+2 cycles.
- busy = (state != IDLE), combinational from the state register.

Test Plan:
1. Assert reset for 2 cycles mid-WAIT -> next cycle: ack=0, busy=0, lfsr_state=0x000, rand_out=0x000, grant_id=0; no ack follows.
2. Defaults (STRIDE=4, LIMIT=511): seed_load with seed=0x000 in cycle c, then req=4'b0001 from cycle c+1 -> ack=4'b0001 in cycle c+6 only, rand_out=0x1E0, busy high c+2..c+6.
3. Same stimulus with LIMIT=9'h0FF -> samples 0x1E0 and 0x1F0 rejected; ack=4'b0001 in cycle c+8, rand_out=0x0F8.
4. req=4'b1111 held constantly after reset -> acks in order 0001,0010,0100,1000,0001, spaced 6 cycles apart; grant_id follows 0,1,2,3,0.
5. seed_load with seed=0x1FF -> lfsr_state=0x000 next cycle, then 0x100, then 0x180.
6. req[2] raised in cycle c and dropped in cycle c+2 while req[1] is raised in c+3 -> ack=4'b0100 still pulses in c+5; the req[1] grant follows with ack=4'b0010 in c+11.

Source files
------------

// File: rtl/rng_share_ctrl.sv
// rtl/rng_share_ctrl.sv - round-robin shared 9-bit XNOR LFSR random source
//
// Purpose: owns one free-running 9-bit XNOR LFSR and hands single draws to
// N_REQ requesters in round-robin order. Each grant discards STRIDE LFSR
// steps before sampling, rejects samples above LIMIT, and completes with a
// one-cycle one-hot ack pulse.
//
// Ports:
//   clk         clock
//   reset       synchronous active-high reset
//   req         level request per requester
//   ack         one-hot, one-cycle completion pulse (rand_out valid while high)
//   rand_out    delivered random value, held until the next accepted sample
//   grant_id    index of the current or last winner
//   busy        high when the FSM is not idle
//   seed_load   load seed into the LFSR on this edge
//   seed        seed value
//   lfsr_state  current LFSR register

module rng_share_ctrl #(
    parameter int         N_REQ  = 4,
    parameter int         STRIDE = 4,
    parameter logic [8:0] LIMIT  = 9'd511
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         ack,
    output logic [8:0]               rand_out,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    input  logic                     seed_load,
    input  logic [8:0]               seed,
    output logic [8:0]               lfsr_state
);

    localparam int GW = $clog2(N_REQ);
    localparam int CW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [CW-1:0]    CNT_INIT = CW'(STRIDE - 1);
    localparam logic [GW-1:0]    LAST_ID  = GW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [GW-1:0] rr_ptr;
    logic [8:0]    lfsr;

    logic          win_found;
    logic [GW-1:0] win_idx;
    int            idx;

    assign lfsr_state = lfsr;
    assign busy       = (state != ST_IDLE);

    // Rotating priority scan: first set request starting at rr_ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx[GW-1:0];
            end
        end
    end

    // LFSR runs independently of the FSM. All-ones is the XNOR lockup state,
    // so a seed of 0x1FF is replaced by 0x000.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= 9'h000;
        end else if (seed_load) begin
            lfsr <= (seed == 9'h1FF) ? 9'h000 : seed;
        end else begin
            lfsr <= {lfsr[0] ~^ lfsr[4], lfsr[8:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rr_ptr   <= '0;
            grant_id <= '0;
            ack      <= '0;
            rand_out <= 9'h000;
        end else begin
            case (state)
                ST_IDLE: begin
                    ack <= '0;
                    if (win_found) begin
                        grant_id <= win_idx;
                        cnt      <= CNT_INIT;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (lfsr <= LIMIT) begin
                        rand_out <= lfsr;
                        ack      <= ONE_HOT0 << grant_id;
                        rr_ptr   <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                        state    <= ST_HOLD;
                    end
                    // Rejected sample: stay and retest the next LFSR value.
                end
                ST_HOLD: begin
                    ack   <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    ack   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rng_share_ctrl.sv
// tb/tb_rng_share_ctrl.sv - directed self-checking bench for rng_share_ctrl

module tb_rng_share_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       seed_load;
    logic [8:0] seed;

    logic [3:0] ack;
    logic [8:0] rand_out;
    logic [1:0] grant_id;
    logic       busy;
    logic [8:0] lfsr_state;

    logic [3:0] ack_l;
    logic [8:0] rand_out_l;
    logic [1:0] grant_id_l;
    logic       busy_l;
    logic [8:0] lfsr_state_l;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rng_share_ctrl #(.N_REQ(4), .STRIDE(4), .LIMIT(9'd511)) dut (
        .clk(clk), .reset(reset), .req(req), .ack(ack), .rand_out(rand_out),
        .grant_id(grant_id), .busy(busy), .seed_load(seed_load), .seed(seed),
        .lfsr_state(lfsr_state)
    );

    rng_share_ctrl #(.N_REQ(4), .STRIDE(4), .LIMIT(9'h0FF)) dut_lim (
        .clk(clk), .reset(reset), .req(req), .ack(ack_l), .rand_out(rand_out_l),
        .grant_id(grant_id_l), .busy(busy_l), .seed_load(seed_load), .seed(seed),
        .lfsr_state(lfsr_state_l)
    );

    // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req       = '0;
        seed_load = 1'b0;
        seed      = '0;
        reset     = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset_state();
        do_reset();
        vectors++;
        if (ack !== 4'b0000 || busy !== 1'b0 || lfsr_state !== 9'h000 ||
            rand_out !== 9'h000 || grant_id !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_state: ack=%b busy=%b lfsr=%h rand=%h gid=%0d, want 0000 0 000 000 0",
                     ack, busy, lfsr_state, rand_out, grant_id);
        end
    endtask

    // Seed 0 at cycle c, req[0] from c+1: ack at c+6 with 0x1E0 (LIMIT 511)
    // and at c+8 with 0x0F8 (LIMIT 0x0FF, 0x1E0 and 0x1F0 rejected).
    task automatic run_seeded_draw(input bit check_limit);
        logic [3:0] exp_ack;
        logic       exp_busy;
        do_reset();
        seed_load = 1'b1;
        seed      = 9'h000;
        step();
        seed_load = 1'b0;
        req       = 4'b0001;
        for (int i = 2; i <= 9; i++) begin
            step();
            if (i == 6) req = 4'b0000;
            if (!check_limit) begin
                exp_ack  = (i == 6) ? 4'b0001 : 4'b0000;
                exp_busy = (i >= 2 && i <= 6);
                vectors++;
                if (ack !== exp_ack || busy !== exp_busy) begin
                    miscompares++;
                    $display("FAIL basic c+%0d: ack=%b busy=%b, want %b %b", i, ack, busy, exp_ack, exp_busy);
                end
                if (i == 6) begin
                    vectors++;
                    if (rand_out !== 9'h1E0) begin
                        miscompares++;
                        $display("FAIL basic rand_out: got %h want 1e0", rand_out);
                    end
                end
            end else begin
                exp_ack = (i == 8) ? 4'b0001 : 4'b0000;
                vectors++;
                if (ack_l !== exp_ack) begin
                    miscompares++;
                    $display("FAIL limit c+%0d: ack=%b want %b", i, ack_l, exp_ack);
                end
                if (i == 8) begin
                    vectors++;
                    if (rand_out_l !== 9'h0F8) begin
                        miscompares++;
                        $display("FAIL limit rand_out: got %h want 0f8", rand_out_l);
                    end
                end
            end
        end
    endtask

    task automatic test_basic();
        run_seeded_draw(1'b0);
    endtask

    task automatic test_limit();
        run_seeded_draw(1'b1);
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_seq [5];
        int n;
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
        do_reset();
        req = 4'b1111;
        n = 0;
        for (int i = 1; i <= 40 && n < 5; i++) begin
            step();
            if (ack !== 4'b0000) begin
                vectors++;
                if (ack !== exp_seq[n] || i != 5 + 6 * n || grant_id !== 2'(n % 4)) begin
                    miscompares++;
                    $display("FAIL rr ack#%0d: ack=%b at k+%0d gid=%0d, want %b at k+%0d gid=%0d",
                             n, ack, i, grant_id, exp_seq[n], 5 + 6 * n, n % 4);
                end
                n++;
            end
        end
        req = 4'b0000;
        vectors++;
        if (n != 5) begin
            miscompares++;
            $display("FAIL rr count: got %0d acks want 5", n);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic seen;
        do_reset();
        req = 4'b0100;
        step();
        step();
        req = 4'b0000;
        vectors++;
        if (busy !== 1'b1 || grant_id !== 2'd2) begin
            miscompares++;
            $display("FAIL mid_wait setup: busy=%b gid=%0d, want 1 2", busy, grant_id);
        end
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        vectors++;
        if (ack !== 4'b0000 || busy !== 1'b0 || lfsr_state !== 9'h000 ||
            rand_out !== 9'h000 || grant_id !== 2'd0) begin
            miscompares++;
            $display("FAIL mid_wait reset: ack=%b busy=%b lfsr=%h rand=%h gid=%0d, want 0000 0 000 000 0",
                     ack, busy, lfsr_state, rand_out, grant_id);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ack !== 4'b0000) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL mid_wait no_ack: ack seen=1 want 0");
        end
    endtask

    task automatic test_seed_lockup();
        logic [8:0] exp_l [3];
        exp_l[0] = 9'h000; exp_l[1] = 9'h100; exp_l[2] = 9'h180;
        do_reset();
        step();
        step();
        seed_load = 1'b1;
        seed      = 9'h1FF;
        step();
        seed_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (lfsr_state !== exp_l[i]) begin
                miscompares++;
                $display("FAIL seed_lockup step%0d: lfsr=%h want %h", i, lfsr_state, exp_l[i]);
            end
            step();
        end
    endtask

    task automatic test_drop_req();
        logic [3:0] exp_ack;
        do_reset();
        req = 4'b0100;
        for (int i = 1; i <= 13; i++) begin
            step();
            if (i == 2) req = 4'b0000;
            if (i == 3) req = 4'b0010;
            if (i == 11) req = 4'b0000;
            exp_ack = (i == 5) ? 4'b0100 : (i == 11) ? 4'b0010 : 4'b0000;
            vectors++;
            if (ack !== exp_ack) begin
                miscompares++;
                $display("FAIL drop_req c+%0d: ack=%b want %b", i, ack, exp_ack);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        req       = '0;
        seed_load = 1'b0;
        seed      = '0;
        test_reset_state();
        test_basic();
        test_limit();
        test_back_to_back();
        test_reset_mid_wait();
        test_seed_lockup();
        test_drop_req();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
